// File: rtl/sm3_add_arbiter_if.sv
// Request/response bundle for sm3_add_arbiter: two operand-bundle requesters and one result port.
// The master modport is the requester/consumer side; the slave modport is the arbiter itself.
interface sm3_add_arbiter_if #(
  parameter int NOPS = 4
);
  logic                 in0_valid;
  logic                 in0_ready;
  logic [32*NOPS-1:0]   in0_ops;
  logic                 in1_valid;
  logic                 in1_ready;
  logic [32*NOPS-1:0]   in1_ops;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_sum;
  logic                 out_ch;
  logic                 busy;

  modport master (
    output in0_valid, in0_ops, in1_valid, in1_ops, out_ready,
    input  in0_ready, in1_ready, out_valid, out_sum, out_ch, busy
  );

  modport slave (
    input  in0_valid, in0_ops, in1_valid, in1_ops, out_ready,
    output in0_ready, in1_ready, out_valid, out_sum, out_ch, busy
  );
endinterface

// File: rtl/sm3_add_arbiter.sv
// Two-requester serial multi-operand adder sharing one 32-bit adder (SM3 TT1/TT2 sums).
// Define SM3_ADD_ARB_RR_EN for round-robin tie-breaking; otherwise channel 0 has fixed priority.
module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] c
);
  assign c = a + b;
endmodule

module sm3_add_arbiter #(
  parameter int NOPS = 4
) (
  input  logic               clk,
  input  logic               rst,
  sm3_add_arbiter_if.slave   bus
);
  localparam int IDXW = $clog2(NOPS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic                  accept_s;
  logic                  grant_s;
  logic [32*NOPS-1:0]    sel_ops_s;
  logic [31:0]           sum_s;
  logic [31:0]           op_r [NOPS];
  logic [31:0]           acc_r;
  logic [IDXW-1:0]       idx_r;
  logic                  last_grant_r;
  logic                  out_ch_r;
  logic                  out_valid_r;
  logic                  busy_r;

  adder u_adder (
    .a (acc_r),
    .b (op_r[idx_r]),
    .c (sum_s)
  );

  assign sel_ops_s     = grant_s ? bus.in1_ops : bus.in0_ops;
  assign bus.in0_ready = accept_s & ~grant_s;
  assign bus.in1_ready = accept_s & grant_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = acc_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.busy      = busy_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state, arbitration and accept decode.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    grant_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.in0_valid || bus.in1_valid) begin
          accept_s     = 1'b1;
          next_state_s = ST_SUM;
`ifdef SM3_ADD_ARB_RR_EN
          if (bus.in0_valid && bus.in1_valid) begin
            grant_s = ~last_grant_r;
          end else begin
            grant_s = ~bus.in0_valid;
          end
`else
          grant_s = ~bus.in0_valid;
`endif
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SUM: begin
        if (idx_r == IDXW'(NOPS - 1)) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_SUM;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, serial accumulation and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r        <= 32'd0;
      idx_r        <= '0;
      last_grant_r <= 1'b1;
      out_ch_r     <= 1'b0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      for (int k = 0; k < NOPS; k++) begin
        op_r[k] <= 32'd0;
      end
    end else begin
      busy_r      <= (next_state_s != ST_IDLE);
      out_valid_r <= (next_state_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            for (int k = 0; k < NOPS; k++) begin
              op_r[k] <= sel_ops_s[32*k +: 32];
            end
            acc_r        <= sel_ops_s[31:0];
            idx_r        <= IDXW'(1);
            out_ch_r     <= grant_s;
            last_grant_r <= grant_s;
          end else begin
            acc_r        <= acc_r;
            idx_r        <= idx_r;
            out_ch_r     <= out_ch_r;
            last_grant_r <= last_grant_r;
          end
        end
        ST_SUM: begin
          // Wraps mod 2^32: carry-out of the shared adder is deliberately dropped.
          acc_r        <= sum_s;
          idx_r        <= idx_r + IDXW'(1);
          last_grant_r <= last_grant_r;
        end
        ST_DONE: begin
          acc_r        <= acc_r;
          idx_r        <= idx_r;
          last_grant_r <= last_grant_r;
        end
        default: begin
          acc_r        <= 32'd0;
          idx_r        <= '0;
          last_grant_r <= last_grant_r;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sm3_add_arbiter.sv
// Directed plus randomized bench for sm3_add_arbiter with an arithmetic reference model.
module tb_sm3_add_arbiter;
  localparam int NOPS = 4;
  localparam int W    = 32*NOPS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic model_last = 1'b1;

  sm3_add_arbiter_if #(.NOPS(NOPS)) bus ();

  sm3_add_arbiter #(.NOPS(NOPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Reference sum: add the operands at full precision, then keep the low 32 bits.
  function automatic logic [31:0] ref_sum(input logic [W-1:0] ops);
    logic [63:0] s;
    s = 64'd0;
    for (int k = 0; k < NOPS; k++) s = s + {32'd0, ops[32*k +: 32]};
    return s[31:0];
  endfunction

  // Reference arbitration: lone requester wins; ties follow the configured policy.
  function automatic logic ref_grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
`ifdef SM3_ADD_ARB_RR_EN
      return ~last;
`else
      return 1'b0;
`endif
    end
    return v1 && !v0;
  endfunction

  // Presents a bundle in IDLE and follows it through accept, summation, backpressure and handshake.
  task automatic one_bundle(input logic v0, input logic v1, input logic [W-1:0] o0,
                            input logic [W-1:0] o1, input int bp);
    logic        ech;
    logic [31:0] esum;
    ech  = ref_grant(v0, v1, model_last);
    esum = ech ? ref_sum(o1) : ref_sum(o0);
    model_last = ech;
    bus.in0_valid = v0;
    bus.in1_valid = v1;
    bus.in0_ops   = o0;
    bus.in1_ops   = o1;
    bus.out_ready = (bp == 0);
    #1;
    chk("accept_in0_ready", {31'd0, bus.in0_ready}, {31'd0, ~ech});
    chk("accept_in1_ready", {31'd0, bus.in1_ready}, {31'd0, ech});
    step();
    bus.in0_ops = {$urandom, $urandom, $urandom, $urandom};
    bus.in1_ops = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 1; c < NOPS; c++) begin
      chk("sum_busy", {31'd0, bus.busy}, 32'd1);
      chk("sum_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("sum_ready", {30'd0, bus.in1_ready, bus.in0_ready}, 32'd0);
      step();
    end
    for (int c = 0; c < bp; c++) begin
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_out_sum", bus.out_sum, esum);
      chk("bp_out_ch", {31'd0, bus.out_ch}, {31'd0, ech});
      chk("bp_ready", {30'd0, bus.in1_ready, bus.in0_ready}, 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("done_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("done_out_sum", bus.out_sum, esum);
    chk("done_out_ch", {31'd0, bus.out_ch}, {31'd0, ech});
    chk("done_busy", {31'd0, bus.busy}, 32'd1);
    chk("done_ready", {30'd0, bus.in1_ready, bus.in0_ready}, 32'd0);
    step();
    chk("post_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("post_busy", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] r0;
    logic [W-1:0] r1;
    logic         rv0;
    logic         rv1;
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.in0_ops   = '0;
    bus.in1_ops   = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_out_sum", bus.out_sum, 32'd0);
    chk("rst_out_ch", {31'd0, bus.out_ch}, 32'd0);
    chk("rst_ready", {30'd0, bus.in1_ready, bus.in0_ready}, 32'd0);

    // Basic sum and wrap-around.
    one_bundle(1'b1, 1'b0, pack(32'd1, 32'd2, 32'd3, 32'd4), '0, 0);
    bus.in0_valid = 1'b0;
    one_bundle(1'b0, 1'b1, '0, pack(32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0), 0);

    // Continuous tie: policy decides alternation or starvation.
    for (int i = 0; i < 4; i++) begin
      one_bundle(1'b1, 1'b1, pack(32'd4, 32'd4, 32'd4, 32'd4),
                 pack(32'd8, 32'd8, 32'd8, 32'd8), 0);
    end

    // Backpressure for 5 cycles with both requesters waiting.
    one_bundle(1'b1, 1'b1, pack(32'h10, 32'h20, 32'h30, 32'h40),
               pack(32'hA, 32'hB, 32'hC, 32'hD), 5);

    // Reset in the middle of summation.
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    step();
    bus.in0_valid = 1'b1;
    bus.in0_ops   = pack(32'd1, 32'd2, 32'd3, 32'd4);
    #1;
    chk("rst_mid_accept", {31'd0, bus.in0_ready}, 32'd1);
    step();
    bus.in0_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_last = 1'b1;
    chk("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_out_sum", bus.out_sum, 32'd0);
    one_bundle(1'b1, 1'b1, pack(32'd5, 32'd5, 32'd5, 32'd5),
               pack(32'd7, 32'd7, 32'd7, 32'd7), 0);

    // Randomized traffic with idle gaps and random backpressure.
    for (int i = 0; i < 40; i++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      r0  = {$urandom, $urandom, $urandom, $urandom};
      r1  = {$urandom, $urandom, $urandom, $urandom};
      if (!rv0 && !rv1) begin
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        #1;
        chk("idle_ready", {30'd0, bus.in1_ready, bus.in0_ready}, 32'd0);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        step();
      end else begin
        one_bundle(rv0, rv1, r0, r1, int'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
